// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit seven-segment scan multiplexer.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [1:0] AN_OFF  = 2'b11;

endpackage

// File: rtl/seg_scan_timer.sv
// Phase counter for the scan FSM: clears on state change, saturates at the
// terminal count of the current phase (SHOW length or BLANK length).
module seg_scan_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic blank_sel,
  output logic tc
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // A zero-length blank phase is terminal on its very first clock.
    if (blank_sel) tc = (BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST);
    else           tc = (cnt_q == SHOW_LAST);

    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (!tc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_mux_2digit.sv
// Two-digit common-anode scan multiplexer with blanking gaps and tear-free capture.
// Optional anode dimming via macro SEG_SCAN_DIM_EN (adds brightness port).
module seg_scan_mux_2digit
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic [0:6] digit1,
  input  logic [0:6] digit0,
  input  logic       indicator,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic [0:6] seg,
  output logic       dp,
  output logic [1:0] an
);

  scan_state_e state_q, state_d;
  logic        tc;
  logic        blank_sel;
  logic        state_chg;

  logic [0:6]  shown_q, shown_d;
  logic [0:6]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [1:0]  an_q, an_d;

`ifdef SEG_SCAN_DIM_EN
  logic [3:0]  pwm_q, pwm_d;
`endif

  assign blank_sel = (state_q == BLANK0) || (state_q == BLANK1);
  assign state_chg = (state_d != state_q);

  seg_scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clkIn),
    .rst_n    (rst),
    .clr      (state_chg),
    .blank_sel(blank_sel),
    .tc       (tc)
  );

  always_comb begin
    state_d = state_q;
    if (tc) begin
      case (state_q)
        SHOW0:   state_d = (BLANK_CYCLES == 0) ? SHOW1 : BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = (BLANK_CYCLES == 0) ? SHOW0 : BLANK1;
        default: state_d = SHOW0;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the entering edge.
  always_comb begin
    shown_d = shown_q;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    an_d    = AN_OFF;
`ifdef SEG_SCAN_DIM_EN
    pwm_d   = pwm_q + 4'd1;
`endif
    case (state_d)
      SHOW0: begin
        if (state_chg) shown_d = digit0;
        seg_d = shown_d;
        dp_d  = ~indicator;
        an_d  = 2'b10;
      end
      SHOW1: begin
        if (state_chg) shown_d = digit1;
        seg_d = shown_d;
        an_d  = 2'b01;
      end
      default: ;
    endcase
`ifdef SEG_SCAN_DIM_EN
    if (!(pwm_d < brightness)) an_d = AN_OFF;
`endif
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      state_q <= BLANK1;
      shown_q <= SEG_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

`ifdef SEG_SCAN_DIM_EN
  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) pwm_q <= 4'd0;
    else      pwm_q <= pwm_d;
  end
`endif

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_mux_2digit.sv
// Scoreboard bench: two instances (one blank clock / no blank) compared against a
// frame-position reference model; checks tearing, overlap and async reset.
module tb_seg_scan_mux_2digit;

  localparam int R = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
  } exp_t;

  localparam exp_t BLANK_OUT = '{seg: 7'b1111111, dp: 1'b1, an: 2'b11};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:6] digit1 = 7'b1111111;
  logic [0:6] digit0 = 7'b1111111;
  logic       indicator = 1'b0;

  logic [0:6] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [1:0] an_a, an_b;

  int errors = 0;
  int checks = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  seg_scan_mux_2digit #(.REFRESH_DIV(R), .BLANK_CYCLES(1), .CNT_W(16)) dut_a (
    .clkIn(clk), .rst(rst), .digit1(digit1), .digit0(digit0),
    .indicator(indicator), .seg(seg_a), .dp(dp_a), .an(an_a)
  );

  seg_scan_mux_2digit #(.REFRESH_DIV(R), .BLANK_CYCLES(0), .CNT_W(16)) dut_b (
    .clkIn(clk), .rst(rst), .digit1(digit1), .digit0(digit0),
    .indicator(indicator), .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  // Phase of the k-th clock edge after reset release:
  // 0 = blank, 1 = SHOW0 entry, 2 = SHOW0 hold, 3 = SHOW1 entry, 4 = SHOW1 hold.
  function automatic int phase_of(input int kk, input int b);
    int o, m;
    o = (b == 0) ? 1 : b;
    if (kk < o) return 0;
    m = (kk - o) % (2 * (R + b));
    if (m < R)         return (m == 0) ? 1 : 2;
    if (m < R + b)     return 0;
    if (m < 2 * R + b) return (m == R + b) ? 3 : 4;
    return 0;
  endfunction

  function automatic exp_t outputs_of(input int ph, input logic [6:0] cap, input logic ind);
    exp_t e;
    e = BLANK_OUT;
    if (ph == 1 || ph == 2) begin
      e.seg = cap; e.dp = ~ind; e.an = 2'b10;
    end else if (ph == 3 || ph == 4) begin
      e.seg = cap; e.dp = 1'b1; e.an = 2'b01;
    end
    return e;
  endfunction

  task automatic chk_out(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got seg=%b dp=%b an=%b, want seg=%b dp=%b an=%b",
               name, act.seg, act.dp, act.an, exp.seg, exp.dp, exp.an);
    end
  endtask

  task automatic chk_val(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Reference model: pushes the expected outputs for every clock edge out of reset.
  initial begin : model
    int         k;
    int         ph;
    logic [6:0] cap_a, cap_b;
    k = 0; cap_a = 7'h7F; cap_b = 7'h7F;
    forever begin
      @(posedge clk);
      if (!rst) begin
        k = 0; cap_a = 7'h7F; cap_b = 7'h7F;
      end else begin
        k++;
        ph = phase_of(k, 1);
        if (ph == 1) cap_a = digit0;
        if (ph == 3) cap_a = digit1;
        qa.push_back(outputs_of(ph, cap_a, indicator));
        ph = phase_of(k, 0);
        if (ph == 1) cap_b = digit0;
        if (ph == 3) cap_b = digit1;
        qb.push_back(outputs_of(ph, cap_b, indicator));
      end
    end
  end

  // Monitor: compares on the falling edge, plus anode-overlap invariants.
  initial begin : monitor
    exp_t       e;
    logic [1:0] prev_a;
    prev_a = 2'b11;
    forever begin
      @(negedge clk);
      if (!rst) begin
        qa.delete(); qb.delete();
        chk_out("reset_a", {seg_a, dp_a, an_a}, BLANK_OUT);
        chk_out("reset_b", {seg_b, dp_b, an_b}, BLANK_OUT);
      end else begin
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk_out("scan_a", {seg_a, dp_a, an_a}, e);
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk_out("scan_b", {seg_b, dp_b, an_b}, e);
        end
      end
      checks++;
      if (an_a == 2'b00 || an_b == 2'b00) begin
        errors++;
        $display("FAIL an_both_on: got an_a=%b an_b=%b, want neither 00", an_a, an_b);
      end
      checks++;
      if ((prev_a == 2'b10 && an_a == 2'b01) || (prev_a == 2'b01 && an_a == 2'b10)) begin
        errors++;
        $display("FAIL an_gap_a: got %b -> %b, want 11 in between", prev_a, an_a);
      end
      prev_a = an_a;
    end
  end

  task automatic random_cycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 2) == 0) digit0 = 7'($urandom);
      if ($urandom_range(0, 2) == 0) digit1 = 7'($urandom);
      indicator = 1'($urandom);
    end
  endtask

  initial begin : stim
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("reset held: outputs blank");
    digit0 = 7'b0000001;
    digit1 = 7'b0010010;
    rst = 1'b1;

    $display("tearing: digit0 changed mid SHOW0");
    repeat (2) @(posedge clk);
    #1 digit0 = 7'b1001111;
    repeat (2) @(posedge clk);
    #1 chk_val("tear_hold", seg_a, 7'b0000001);
    repeat (7) @(posedge clk);
    #1 chk_val("tear_next", seg_a, 7'b1001111);

    $display("random scan: 200 cycles");
    random_cycles(200);

    $display("async reset mid SHOW1");
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk_val("pre_reset_show1", {5'b0, an_a}, 7'b0000001);
    #1 rst = 1'b0;
    #1 chk_out("async_blank_a", {seg_a, dp_a, an_a}, BLANK_OUT);
    chk_out("async_blank_b", {seg_b, dp_b, an_b}, BLANK_OUT);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk_val("recover_an", {5'b0, an_a}, 7'b0000010);
    chk_val("recover_seg", seg_a, digit0);

    $display("random scan after reset: 200 cycles");
    random_cycles(200);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
